// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_BUSY_I = 2'b01,
    ARB_BUSY_D = 2'b10
  } arb_state_t;

  localparam int ARB_MAX_STREAK_DEF = 4;
  localparam int ARB_TIMEOUT_DEF    = 255;

endpackage

// File: rtl/arb_streak_cnt.sv
// Saturating 3-bit counter of consecutive data grants taken while fetch waits.
module arb_streak_cnt #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [2:0] cnt_q, cnt_d;

  assign sat = (cnt_q == 3'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = 3'd0;
    else if (inc && !sat)
      cnt_d = cnt_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= 3'd0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Per-transaction arbiter sharing one single-port memory between fetch and data; data wins unless fetch starves.
// MEM_ARB_TIMEOUT_EN adds a BUSY watchdog and the arb_err port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STREAK = ARB_MAX_STREAK_DEF,
  parameter int TIMEOUT    = ARB_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [2:0]    d_type,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [2:0]    m_type,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata,
  output logic          pipe_stall
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic          arb_err
`endif
);

  arb_state_t    state_q, state_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [2:0]    m_type_q, m_type_d;

  logic busy_i, busy_d, busy, arb_pt, pick_i, pick_d, to_fire, sat;

  assign busy_i = (state_q == ARB_BUSY_I);
  assign busy_d = (state_q == ARB_BUSY_D);
  assign busy   = busy_i | busy_d;
  // Completion and next pick share the same cycle, so back-to-back transfers have no bubble.
  assign arb_pt = (state_q == ARB_IDLE) | (busy & m_ack);
  assign pick_d = ~rst & arb_pt & d_req & ~(i_req & sat);
  assign pick_i = ~rst & arb_pt & i_req & ~pick_d;

  arb_streak_cnt #(.MAX(MAX_STREAK)) u_streak (
    .clk (clk),
    .rst (rst),
    .inc (pick_d & i_req),
    .clr (pick_i | ~i_req),
    .sat (sat)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] wd_q, wd_d;

  assign to_fire = busy & ~m_ack & (wd_q == 8'(TIMEOUT));
  assign arb_err = ~rst & to_fire;

  always_comb begin
    wd_d = wd_q + 8'd1;
    if (arb_pt || to_fire)
      wd_d = 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      wd_q <= 8'd0;
    else
      wd_q <= wd_d;
  end
`else
  logic unused_timeout;
  assign to_fire        = 1'b0;
  assign unused_timeout = |TIMEOUT;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_type_q  <= 3'd0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_type_q  <= m_type_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (pick_d)
      state_d = ARB_BUSY_D;
    else if (pick_i)
      state_d = ARB_BUSY_I;
    else if (arb_pt || to_fire)
      state_d = ARB_IDLE;
  end

  always_comb begin
    i_gnt    = pick_i;
    d_gnt    = pick_d;
    i_rvalid = ~rst & busy_i & (m_ack | to_fire);
    d_rvalid = ~rst & busy_d & (m_ack | to_fire);
    // Timeout completions report zero data; only a real ack passes memory data through.
    i_rdata  = (~rst & busy_i & m_ack) ? m_rdata : '0;
    d_rdata  = (~rst & busy_d & m_ack) ? m_rdata : '0;
  end

  always_comb begin
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_type_d  = m_type_q;
    if (pick_d) begin
      m_req_d   = 1'b1;
      m_we_d    = d_we;
      m_addr_d  = d_addr;
      m_wdata_d = d_wdata;
      m_type_d  = d_type;
    end else if (pick_i) begin
      m_req_d   = 1'b1;
      m_we_d    = 1'b0;
      m_addr_d  = i_addr;
      m_wdata_d = '0;
      m_type_d  = 3'd0;
    end else if (arb_pt || to_fire) begin
      m_req_d   = 1'b0;
    end
  end

  assign m_req      = m_req_q;
  assign m_we       = m_we_q;
  assign m_addr     = m_addr_q;
  assign m_wdata    = m_wdata_q;
  assign m_type     = m_type_q;
  assign pipe_stall = (i_req & ~i_rvalid) | ((d_req | busy_d) & ~d_rvalid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge, outputs are checked 1ns later.
module tb_mem_arbiter;

  localparam logic [2:0] DM_SB = 3'b101;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TB_TO = 5;
`else
  localparam int TB_TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [2:0]  d_type, m_type;
  logic        m_req, m_we, m_ack, pipe_stall;
  logic [31:0] m_addr, m_wdata, m_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        arb_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .MAX_STREAK(4), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_type(d_type),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_type(m_type),
    .m_ack(m_ack), .m_rdata(m_rdata), .pipe_stall(pipe_stall)
`ifdef MEM_ARB_TIMEOUT_EN
    , .arb_err(arb_err)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  // Starvation pattern: four data grants, one fetch, then data again.
  logic [5:0] st_dg = 6'b101111;
  logic [5:0] st_ig = 6'b010000;

  initial begin
    rst = 1'b1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_type = 0; m_ack = 0; m_rdata = 0;
    cyc(); cyc(); settle();
    chk("rst_m_req", m_req, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_gnt", {i_gnt, d_gnt}, 0);
    chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
    cyc(); rst = 1'b0; settle();
    chk("idle_stall", pipe_stall, 0);

    // Single fetch, ack two cycles after the grant
    cyc(); i_req = 1; i_addr = 32'h10; settle();
    chk("f_i_gnt", i_gnt, 1);
    chk("f_d_gnt", d_gnt, 0);
    chk("f_stall", pipe_stall, 1);
    cyc(); i_req = 0; i_addr = 32'hFFFF_FFF0; settle();
    chk("f_m_req1", m_req, 1);
    chk("f_m_addr", m_addr, 32'h10);
    chk("f_rvalid_early", i_rvalid, 0);
    cyc(); m_ack = 1; m_rdata = 32'h0051_3093; settle();
    chk("f_m_req2", m_req, 1);
    chk("f_i_rvalid", i_rvalid, 1);
    chk("f_i_rdata", i_rdata, 32'h0051_3093);
    cyc(); m_ack = 0; settle();
    chk("f_m_req_drop", m_req, 0);
    chk("f_rdata_zero", i_rdata, 0);

    // Collision, ack every cycle (ack in IDLE is ignored)
    cyc(); i_req = 1; i_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h100; m_ack = 1;
    m_rdata = 32'h1111; settle();
    chk("c_d_gnt", d_gnt, 1);
    chk("c_i_gnt0", i_gnt, 0);
    chk("c_idle_ack", d_rvalid, 0);
    chk("c_stall0", pipe_stall, 1);
    cyc(); d_req = 0; m_rdata = 32'hAAAA; settle();
    chk("c_m_addr_d", m_addr, 32'h100);
    chk("c_d_rvalid", d_rvalid, 1);
    chk("c_d_rdata", d_rdata, 32'hAAAA);
    chk("c_i_gnt1", i_gnt, 1);
    chk("c_stall1", pipe_stall, 1);
    cyc(); i_req = 0; m_rdata = 32'hBBBB; settle();
    chk("c_m_addr_i", m_addr, 32'h20);
    chk("c_i_rvalid", i_rvalid, 1);
    chk("c_i_rdata", i_rdata, 32'hBBBB);
    chk("c_d_rdata0", d_rdata, 0);
    chk("c_stall2", pipe_stall, 0);
    cyc(); m_ack = 0; settle();
    chk("c_m_req_drop", m_req, 0);

    // Starvation guard
    cyc(); i_req = 1; i_addr = 32'h40; d_req = 1; d_addr = 32'h300; m_ack = 1; settle();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin cyc(); settle(); end
      chk($sformatf("s_d_gnt%0d", k), d_gnt, st_dg[k]);
      chk($sformatf("s_i_gnt%0d", k), i_gnt, st_ig[k]);
    end
    cyc(); i_req = 0; d_req = 0; settle();
    chk("s_fetch_done", i_rvalid, 0);
    chk("s_d_done", d_rvalid, 1);
    cyc(); m_ack = 0; settle();
    chk("s_m_req_drop", m_req, 0);

    // Store: fields latched at grant, later input changes ignored
    cyc(); d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_type = DM_SB; settle();
    chk("st_d_gnt", d_gnt, 1);
    cyc(); d_req = 0; d_we = 0; d_addr = 32'hFFF; d_wdata = 0; d_type = 0; settle();
    chk("st_m_req", m_req, 1);
    chk("st_m_we", m_we, 1);
    chk("st_m_addr", m_addr, 32'h200);
    chk("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("st_m_type", m_type, DM_SB);
    chk("st_rvalid_early", d_rvalid, 0);
    cyc(); m_ack = 1; m_rdata = 0; settle();
    chk("st_d_rvalid", d_rvalid, 1);
    chk("st_d_rdata", d_rdata, 0);
    chk("st_m_addr_hold", m_addr, 32'h200);
    cyc(); m_ack = 0; settle();
    chk("st_m_req_drop", m_req, 0);

    // Reset in second BUSY_D cycle, late ack ignored
    cyc(); d_req = 1; d_we = 0; d_addr = 32'h400; settle();
    chk("r_d_gnt", d_gnt, 1);
    cyc(); d_req = 0; settle();
    chk("r_stall_busy", pipe_stall, 1);
    cyc(); rst = 1; settle();
    chk("r_rvalid_in_rst", d_rvalid, 0);
    cyc(); rst = 0; m_ack = 1; m_rdata = 32'h7777; settle();
    chk("r_m_req", m_req, 0);
    chk("r_no_rvalid", d_rvalid, 0);
    chk("r_stall", pipe_stall, 0);
    cyc(); m_ack = 0; i_req = 1; i_addr = 32'h80; settle();
    chk("r_idle_i_gnt", i_gnt, 1);
    cyc(); i_req = 0; m_ack = 1; m_rdata = 32'h99; settle();
    chk("r_i_rvalid", i_rvalid, 1);
    cyc(); m_ack = 0; settle();
    chk("r_m_req_drop", m_req, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: no ack, timeout five cycles after m_req rises
    cyc(); d_req = 1; d_addr = 32'h500; m_rdata = 32'h5555; settle();
    chk("t_d_gnt", d_gnt, 1);
    cyc(); d_req = 0; settle();
    chk("t_m_req_rise", m_req, 1);
    for (int k = 1; k < 5; k++) begin
      cyc(); settle();
      chk($sformatf("t_no_err%0d", k), arb_err, 0);
    end
    cyc(); settle();
    chk("t_arb_err", arb_err, 1);
    chk("t_d_rvalid", d_rvalid, 1);
    chk("t_d_rdata", d_rdata, 0);
    cyc(); settle();
    chk("t_m_req_drop", m_req, 0);
    chk("t_err_drop", arb_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified memory between the pipeline's instruction-fetch stage and its data-memory stage. Holds at most one memory transaction in flight and arbitrates per transaction. Data wins by default; a streak counter prevents fetch starvation. It sits between the PC/IF_ID fetch path, the EX_MEM load/store path and the memory. It also drives the pipeline-wide stall when a requester is waiting.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_STREAK, 4, consecutive data grants allowed while fetch is pending
- TIMEOUT, 255, watchdog limit in cycles; used only under MEM_ARB_TIMEOUT_EN

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset: synchronous, active-high
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  AW  fetch address
- i_gnt  out  1  fetch accepted this cycle (combinational)
- i_rvalid  out  1  fetch data valid (one-cycle pulse)
- i_rdata  out  DW  fetch data
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_type  in  3  DMType code, forwarded unchanged
- d_gnt  out  1  data accepted this cycle (combinational)
- d_rvalid  out  1  data transaction complete (one-cycle pulse; loads and stores)
- d_rdata  out  DW  load data
- m_req  out  1  memory request (registered)
- m_we, m_addr, m_wdata, m_type  out  1/AW/DW/3  latched transaction fields (registered)
- m_ack  in  1  memory completes the transaction this cycle
- m_rdata  in  DW  read data, valid with m_ack
- pipe_stall  out  1  combinational; (i_req & ~i_rvalid) | (d_req | busy_d) & ~d_rvalid
- arb_err  out  1  timeout pulse; port exists only under MEM_ARB_TIMEOUT_EN

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. Encoding is 2 bits: 00, 01, 10.
- Arbitration point: state IDLE, or any BUSY state in the cycle m_ack=1.
- Pick rule:
  - d_req & ~(i_req & streak==MAX_STREAK) → data.
  - Otherwise i_req → fetch.
  - Otherwise go to IDLE.
- On a pick, the matching x_gnt=1 that cycle. The fields are latched into the m_* registers, and the FSM enters BUSY_x at the next edge.
- In BUSY_x: m_req=1 and m_* fields stay stable.
  - On m_ack: x_rvalid=1 and x_rdata=m_rdata (passthrough) in the same cycle.
  - The arbitration for the next transaction happens in that same cycle.
- Streak counter, 3 bits, saturating at MAX_STREAK:
  - Increments on each data grant while i_req=1.
  - Clears on a fetch grant, or in any cycle with i_req=0.
- i_rdata and d_rdata are 0 whenever their rvalid is 0.
- A requester whose fields change after its grant has no effect on the transaction.

## Timing
- Reset values: state=IDLE, streak=0, m_req=0, m_we=0, m_addr=0, m_wdata=0, m_type=0, all gnt/rvalid=0, arb_err=0.
- Minimum latency: request at cycle t in IDLE gives gnt at t, m_req at t+1, and earliest rvalid at t+1 (m_ack at t+1).
- Back-to-back: with m_ack at cycle c and another request pending, the next grant is at c, m_req stays high across c→c+1 with new fields at c+1. There is no idle bubble.
- Simultaneous i_req and d_req in IDLE grant data, unless streak==MAX_STREAK.
- rst asserted mid-transaction: m_req=0 at the next edge, state=IDLE, and no rvalid is issued for the aborted transfer.
- m_ack while in IDLE is ignored.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - An 8-bit watchdog counts cycles in BUSY_x without m_ack, and clears on every arbitration point.
  - At count==TIMEOUT: arb_err pulses, x_rvalid pulses with x_rdata=0, m_req drops, and the FSM goes to IDLE.
- Undefined: no watchdog, no arb_err port, and a BUSY state waits indefinitely.

## Structure
- Shared package mem_arb_pkg holds:
  - the state encodings ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D;
  - the default MAX_STREAK and TIMEOUT values.
- DMType codes come from the existing control encoding header and are not redefined.
- One sub-module, arb_streak_cnt: the saturating counter with inputs inc, clr and output sat.

## Test plan
- Single fetch: i_req=1, i_addr=0x0000_0010 at t, m_ack at t+2 with m_rdata=0x0051_3093 → i_gnt at t; m_req high at t+1 and t+2; i_rvalid at t+2 with i_rdata=0x0051_3093.
- Collision: i_req and d_req (load 0x100) both rise at t, m_ack every cycle → d_gnt at t; i_gnt at t+1 (back-to-back); pipe_stall high until i_rvalid at t+2.
- Starvation: d_req held continuously with i_req=1, m_ack every cycle → exactly 4 d_gnt, then 1 i_gnt, then data resumes.
- Store passthrough: d_we=1, d_addr=0x200, d_wdata=0xDEAD_BEEF, d_type=sb code → m_we=1 and fields match at m_req; d_rvalid on m_ack; d_rdata=0.
- Reset mid-op: rst at BUSY_D cycle 2, m_ack the cycle after → m_req=0, no d_rvalid, state IDLE.
- Timeout (macro on, TIMEOUT=5): no m_ack → arb_err and d_rvalid pulse 5 cycles after m_req rises, then m_req=0.
